// File: rtl/ram_rdport_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_rdport_arbiter: round-robin, burst-locking share of one RAM read     |
// | port; responses return one-hot tagged with a fixed 2-cycle latency.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_rdport_arbiter #(
  parameter int NREQ   = 4,
  parameter int BDADDR = 12,
  parameter int BDWORD = 32*64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BDADDR-1:0] req_addr,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [BDWORD-1:0]      rsp_word,
  output logic                   ram_rd_en,
  output logic [BDADDR-1:0]      ram_rd_addr,
  input  logic [BDWORD-1:0]      ram_rd_word
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;

  logic              gnt_any;
  logic [IW-1:0]     gnt_idx;

  logic              s1_valid_q;
  logic [IW-1:0]     s1_idx_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [BDWORD-1:0] rsp_word_q;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Arbitration: scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_q == S_LOCK) begin
      if (req_valid[owner_q]) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(rr_ptr_q, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_add(rr_ptr_q, k);
        end
      end
    end
    if (!rst_n) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // A lock persists indefinitely while the owner withholds valid.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (gnt_any) begin
      if (req_last[gnt_idx]) begin
        state_d  = S_IDLE;
        rr_ptr_d = wrap_add(gnt_idx, 1);
      end else begin
        state_d  = S_LOCK;
        owner_d  = gnt_idx;
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    ram_rd_en   = gnt_any;
    ram_rd_addr = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
      ram_rd_addr        = req_addr[gnt_idx*BDADDR +: BDADDR];
    end
  end

  // RAM data is only sampled in the cycle it is known valid, so X never leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      rsp_valid_q <= '0;
      rsp_word_q  <= '0;
    end else begin
      s1_valid_q  <= gnt_any;
      s1_idx_q    <= gnt_idx;
      rsp_valid_q <= s1_valid_q ? (NREQ'(1) << s1_idx_q) : '0;
      if (s1_valid_q) rsp_word_q <= ram_rd_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_word  = rsp_word_q;

endmodule
`default_nettype wire
